// File: rtl/encoder_verif_pkg.sv
// Shared defaults and compare-result type for the encoder result checker.
package encoder_verif_pkg;

  localparam int PIPE_LATENCY_DEF = 3;
  localparam int EXP_DEPTH_DEF    = 8;

  typedef struct packed {
    logic range_ok;
    logic low_ok;
  } cmp_result_t;

  function automatic logic cmp_any_err(input cmp_result_t res);
    return ~(res.range_ok & res.low_ok);
  endfunction

endpackage

// File: rtl/expected_fifo.sv
// Expected-value FIFO whose oldest entry is always presented from a register.
module expected_fifo #(
  parameter int DATA_WIDTH = 40,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         rd_nxt_s;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  do_push_s, do_pop_s;

  // Pointer, occupancy and head-register next state.
  always_comb begin
    do_pop_s  = pop & (count_q != '0);
    do_push_s = push & ((count_q != CNT_FULL) | do_pop_s);
    rd_nxt_s  = rd_ptr_q + PTR_ONE;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_nxt_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Head must track the new oldest entry; a one-deep queue hands off to the incoming word.
      if (do_pop_s) begin
        if (count_q == CNT_ONE) begin
          head_d = do_push_s ? wdata : head_q;
        end else begin
          head_d = mem_q[rd_nxt_s];
        end
      end else if (do_push_s && (count_q == '0)) begin
        head_d = wdata;
      end else begin
        head_d = head_q;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

endmodule

// File: rtl/encoder_result_checker.sv
// Compares encoder range/low outputs against queued expected values at the
// cycle each issued symbol emerges, keeping error counts and the first failure.
module encoder_result_checker
  import encoder_verif_pkg::*;
#(
  parameter int RANGE_WIDTH  = 16,
  parameter int LOW_WIDTH    = 24,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
  parameter int EXP_DEPTH    = EXP_DEPTH_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   general_clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   exp_valid,
  input  logic [RANGE_WIDTH-1:0] exp_range,
  input  logic [LOW_WIDTH-1:0]   exp_low,
  input  logic [RANGE_WIDTH-1:0] dut_range,
  input  logic [LOW_WIDTH-1:0]   dut_low,
  output logic [CNT_WIDTH-1:0]   checked_cnt,
  output logic [CNT_WIDTH-1:0]   range_err_cnt,
  output logic [CNT_WIDTH-1:0]   low_err_cnt,
  output logic                   first_err_valid,
  output logic [CNT_WIDTH-1:0]   first_err_idx,
  output logic [RANGE_WIDTH-1:0] first_err_got_range,
  output logic [RANGE_WIDTH-1:0] first_err_exp_range,
  output logic [LOW_WIDTH-1:0]   first_err_got_low,
  output logic [LOW_WIDTH-1:0]   first_err_exp_low,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   pass
);

  localparam int DW = RANGE_WIDTH + LOW_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [PIPE_LATENCY-1:0] due_sr_q, due_sr_d;
  logic [DW-1:0]           head_s;
  logic [RANGE_WIDTH-1:0]  head_range_s;
  logic [LOW_WIDTH-1:0]    head_low_s;
  logic                    full_s, empty_s, due_s;
  logic                    pop_s, push_s, under_evt_s, over_evt_s;
  cmp_result_t             cmp_s;

  logic [CNT_WIDTH-1:0]   checked_cnt_q, checked_cnt_d;
  logic [CNT_WIDTH-1:0]   range_err_cnt_q, range_err_cnt_d;
  logic [CNT_WIDTH-1:0]   low_err_cnt_q, low_err_cnt_d;
  logic                   first_err_valid_q, first_err_valid_d;
  logic [CNT_WIDTH-1:0]   first_err_idx_q, first_err_idx_d;
  logic [RANGE_WIDTH-1:0] first_err_got_range_q, first_err_got_range_d;
  logic [RANGE_WIDTH-1:0] first_err_exp_range_q, first_err_exp_range_d;
  logic [LOW_WIDTH-1:0]   first_err_got_low_q, first_err_got_low_d;
  logic [LOW_WIDTH-1:0]   first_err_exp_low_q, first_err_exp_low_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   pass_q, pass_d;

  assign due_s        = due_sr_q[PIPE_LATENCY-1];
  assign head_range_s = head_s[DW-1:LOW_WIDTH];
  assign head_low_s   = head_s[LOW_WIDTH-1:0];

  expected_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (EXP_DEPTH)
  ) u_expected_fifo (
    .clk   (general_clk),
    .rst_n (reset),
    .clr   (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({exp_range, exp_low}),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue tracker, queue handshake and compare qualification.
  always_comb begin
    due_sr_d = '0;
    if (flush) begin
      due_sr_d = '0;
    end else begin
      due_sr_d[0] = issue_valid;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        due_sr_d[i] = due_sr_q[i-1];
      end
    end
    cmp_s.range_ok = (head_range_s == dut_range);
    cmp_s.low_ok   = (head_low_s == dut_low);
    pop_s          = due_s & ~empty_s & ~flush;
    push_s         = exp_valid & (~full_s | pop_s) & ~flush;
    under_evt_s    = due_s & empty_s & ~flush;
    over_evt_s     = exp_valid & full_s & ~pop_s & ~flush;
  end

  // Counters, first-error capture and sticky flags.
  always_comb begin
    checked_cnt_d         = checked_cnt_q;
    range_err_cnt_d       = range_err_cnt_q;
    low_err_cnt_d         = low_err_cnt_q;
    first_err_valid_d     = first_err_valid_q;
    first_err_idx_d       = first_err_idx_q;
    first_err_got_range_d = first_err_got_range_q;
    first_err_exp_range_d = first_err_exp_range_q;
    first_err_got_low_d   = first_err_got_low_q;
    first_err_exp_low_d   = first_err_exp_low_q;
    overflow_d            = overflow_q | over_evt_s;
    underflow_d           = underflow_q | under_evt_s;
    if (flush) begin
      checked_cnt_d         = '0;
      range_err_cnt_d       = '0;
      low_err_cnt_d         = '0;
      first_err_valid_d     = 1'b0;
      first_err_idx_d       = '0;
      first_err_got_range_d = '0;
      first_err_exp_range_d = '0;
      first_err_got_low_d   = '0;
      first_err_exp_low_d   = '0;
      overflow_d            = 1'b0;
      underflow_d           = 1'b0;
    end else if (pop_s) begin
      checked_cnt_d = (checked_cnt_q == CNT_MAX) ? checked_cnt_q : checked_cnt_q + CNT_ONE;
      if (!cmp_s.range_ok && (range_err_cnt_q != CNT_MAX)) begin
        range_err_cnt_d = range_err_cnt_q + CNT_ONE;
      end else begin
        range_err_cnt_d = range_err_cnt_q;
      end
      if (!cmp_s.low_ok && (low_err_cnt_q != CNT_MAX)) begin
        low_err_cnt_d = low_err_cnt_q + CNT_ONE;
      end else begin
        low_err_cnt_d = low_err_cnt_q;
      end
      // Index is the pre-increment count, i.e. the zero-based compare number.
      if (cmp_any_err(cmp_s) && !first_err_valid_q) begin
        first_err_valid_d     = 1'b1;
        first_err_idx_d       = checked_cnt_q;
        first_err_got_range_d = dut_range;
        first_err_exp_range_d = head_range_s;
        first_err_got_low_d   = dut_low;
        first_err_exp_low_d   = head_low_s;
      end else begin
        first_err_valid_d = first_err_valid_q;
      end
    end else begin
      checked_cnt_d = checked_cnt_q;
    end
    pass_d = (checked_cnt_d != '0) && (range_err_cnt_d == '0) && (low_err_cnt_d == '0)
             && !overflow_d && !underflow_d;
  end

  // State registers.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      due_sr_q              <= '0;
      checked_cnt_q         <= '0;
      range_err_cnt_q       <= '0;
      low_err_cnt_q         <= '0;
      first_err_valid_q     <= 1'b0;
      first_err_idx_q       <= '0;
      first_err_got_range_q <= '0;
      first_err_exp_range_q <= '0;
      first_err_got_low_q   <= '0;
      first_err_exp_low_q   <= '0;
      overflow_q            <= 1'b0;
      underflow_q           <= 1'b0;
      pass_q                <= 1'b0;
    end else begin
      due_sr_q              <= due_sr_d;
      checked_cnt_q         <= checked_cnt_d;
      range_err_cnt_q       <= range_err_cnt_d;
      low_err_cnt_q         <= low_err_cnt_d;
      first_err_valid_q     <= first_err_valid_d;
      first_err_idx_q       <= first_err_idx_d;
      first_err_got_range_q <= first_err_got_range_d;
      first_err_exp_range_q <= first_err_exp_range_d;
      first_err_got_low_q   <= first_err_got_low_d;
      first_err_exp_low_q   <= first_err_exp_low_d;
      overflow_q            <= overflow_d;
      underflow_q           <= underflow_d;
      pass_q                <= pass_d;
    end
  end

  assign checked_cnt         = checked_cnt_q;
  assign range_err_cnt       = range_err_cnt_q;
  assign low_err_cnt         = low_err_cnt_q;
  assign first_err_valid     = first_err_valid_q;
  assign first_err_idx       = first_err_idx_q;
  assign first_err_got_range = first_err_got_range_q;
  assign first_err_exp_range = first_err_exp_range_q;
  assign first_err_got_low   = first_err_got_low_q;
  assign first_err_exp_low   = first_err_exp_low_q;
  assign overflow            = overflow_q;
  assign underflow           = underflow_q;
  assign pass                = pass_q;

endmodule

// File: tb/tb_encoder_result_checker.sv
// Bench: two checkers (latency 3 and 5) share control inputs; the latency-3 one
// is compared every cycle against a queue-based reference model.
module tb_encoder_result_checker;

  localparam int L3 = 3;
  localparam int L5 = 5;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] r;
    logic [23:0] l;
  } pair_t;

  logic general_clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, issue_valid = 1'b0, exp_valid = 1'b0;
  logic [15:0] exp_range = 16'h0;
  logic [23:0] exp_low = 24'h0;
  logic [15:0] dut_range3 = 16'h0, dut_range5 = 16'h0;
  logic [23:0] dut_low3 = 24'h0, dut_low5 = 24'h0;

  logic [15:0] a_checked, a_rerr, a_lerr, a_fidx, a_fgr, a_fer;
  logic [23:0] a_fgl, a_fel;
  logic        a_fev, a_ovf, a_unf, a_pass;
  logic [15:0] b_checked, b_rerr, b_lerr, b_fidx, b_fgr, b_fer;
  logic [23:0] b_fgl, b_fel;
  logic        b_fev, b_ovf, b_unf, b_pass;

  int tests = 0;
  int fails = 0;

  always #5 general_clk = ~general_clk;

  encoder_result_checker #(.PIPE_LATENCY(L3)) dut (
    .general_clk(general_clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .exp_valid(exp_valid), .exp_range(exp_range), .exp_low(exp_low),
    .dut_range(dut_range3), .dut_low(dut_low3),
    .checked_cnt(a_checked), .range_err_cnt(a_rerr), .low_err_cnt(a_lerr),
    .first_err_valid(a_fev), .first_err_idx(a_fidx),
    .first_err_got_range(a_fgr), .first_err_exp_range(a_fer),
    .first_err_got_low(a_fgl), .first_err_exp_low(a_fel),
    .overflow(a_ovf), .underflow(a_unf), .pass(a_pass));

  encoder_result_checker #(.PIPE_LATENCY(L5)) dut5 (
    .general_clk(general_clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .exp_valid(exp_valid), .exp_range(exp_range), .exp_low(exp_low),
    .dut_range(dut_range5), .dut_low(dut_low5),
    .checked_cnt(b_checked), .range_err_cnt(b_rerr), .low_err_cnt(b_lerr),
    .first_err_valid(b_fev), .first_err_idx(b_fidx),
    .first_err_got_range(b_fgr), .first_err_exp_range(b_fer),
    .first_err_got_low(b_fgl), .first_err_exp_low(b_fel),
    .overflow(b_ovf), .underflow(b_unf), .pass(b_pass));

  // Reference model state.
  pair_t mq[$];
  bit    hist[64];
  int    mcyc = 0;
  int    m_checked = 0, m_rerr = 0, m_lerr = 0, m_fidx = 0;
  bit    m_fev = 0, m_ovf = 0, m_unf = 0;
  pair_t m_fgot = '0, m_fexp = '0;

  // Encoder emulation: result scheduled by step index.
  pair_t slot3[64];
  pair_t slot5[64];
  int    tcyc = 0;
  pair_t push_hist[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    foreach (hist[i]) hist[i] = 1'b0;
    m_checked = 0; m_rerr = 0; m_lerr = 0; m_fidx = 0;
    m_fev = 0; m_ovf = 0; m_unf = 0;
    m_fgot = '0; m_fexp = '0;
  endtask

  task automatic model_step();
    bit    due;
    int    sz;
    bit    popped;
    pair_t h;
    pair_t got;
    if (flush) begin
      model_clear();
    end else begin
      due = hist[(mcyc - L3 + 64) % 64];
      got = {dut_range3, dut_low3};
      sz = mq.size();
      popped = due && (sz > 0);
      if (due && sz == 0) m_unf = 1;
      if (popped) begin
        h = mq.pop_front();
        if ((h.r != got.r || h.l != got.l) && !m_fev) begin
          m_fev = 1; m_fidx = m_checked; m_fgot = got; m_fexp = h;
        end
        if (h.r != got.r && m_rerr < 65535) m_rerr++;
        if (h.l != got.l && m_lerr < 65535) m_lerr++;
        if (m_checked < 65535) m_checked++;
      end
      if (exp_valid) begin
        if (sz < DEPTH || popped) mq.push_back({exp_range, exp_low});
        else m_ovf = 1;
      end
      hist[mcyc % 64] = issue_valid;
    end
    mcyc++;
  endtask

  initial begin
    forever begin
      @(posedge general_clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  // Per-cycle comparison of the latency-3 checker against the model.
  initial begin
    forever begin
      @(negedge general_clk);
      chk("checked_cnt", a_checked, m_checked);
      chk("range_err_cnt", a_rerr, m_rerr);
      chk("low_err_cnt", a_lerr, m_lerr);
      chk("first_err_valid", a_fev, m_fev);
      chk("first_err_idx", a_fidx, m_fidx);
      chk("first_err_got_range", a_fgr, m_fgot.r);
      chk("first_err_exp_range", a_fer, m_fexp.r);
      chk("first_err_got_low", a_fgl, m_fgot.l);
      chk("first_err_exp_low", a_fel, m_fexp.l);
      chk("overflow", a_ovf, m_ovf);
      chk("underflow", a_unf, m_unf);
      chk("pass", a_pass,
          (m_checked > 0 && m_rerr == 0 && m_lerr == 0 && !m_ovf && !m_unf) ? 1 : 0);
    end
  end

  task automatic step(input bit iss, input bit psh, input logic [15:0] pr, input logic [23:0] pl,
                      input logic [15:0] gr, input logic [23:0] gl, input bit fl);
    @(negedge general_clk);
    flush = fl;
    issue_valid = iss;
    exp_valid = psh;
    exp_range = pr;
    exp_low = pl;
    dut_range3 = slot3[tcyc % 64].r;
    dut_low3 = slot3[tcyc % 64].l;
    dut_range5 = slot5[tcyc % 64].r;
    dut_low5 = slot5[tcyc % 64].l;
    if (iss) begin
      slot3[(tcyc + L3) % 64] = {gr, gl};
      slot5[(tcyc + L5) % 64] = {gr, gl};
    end
    tcyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 24'h0, 16'h0, 24'h0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 1'b0, 16'h0, 24'h0, 16'h0, 24'h0, 1'b1);
  endtask

  task automatic run_matched10();
    pair_t v;
    for (int i = 0; i < 10; i++) begin
      v.r = 16'(i * 257 + 1);
      v.l = 24'(i * 4099 + 7);
      step(1'b1, 1'b1, v.r, v.l, v.r, v.l, 1'b0);
    end
  endtask

  initial begin
    pair_t v;
    pair_t w[9];
    pair_t g;
    bit    iss, psh, fl;

    // Reset state.
    idle(2);
    chk("rst_checked", a_checked, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_underflow", a_unf, 0);
    chk("rst_first_err_valid", a_fev, 0);
    reset = 1'b1;
    idle(1);

    // Ten matching results.
    run_matched10();
    idle(3);
    chk("m10_checked_minus1", a_checked, 9);
    idle(1);
    chk("m10_checked", a_checked, 10);
    chk("m10_model_checked", m_checked, 10);
    chk("m10_rerr", a_rerr, 0);
    chk("m10_lerr", a_lerr, 0);
    chk("m10_pass", a_pass, 1);

    // Range mismatch on the third of five.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      v.r = (i == 2) ? 16'h7F00 : 16'(16'h1000 + i);
      v.l = 24'(24'h00A000 + i);
      step(1'b1, 1'b1, v.r, v.l, (i == 2) ? 16'h8000 : v.r, v.l, 1'b0);
    end
    idle(5);
    chk("mm_checked", a_checked, 5);
    chk("mm_rerr", a_rerr, 1);
    chk("mm_model_rerr", m_rerr, 1);
    chk("mm_lerr", a_lerr, 0);
    chk("mm_first_idx", a_fidx, 2);
    chk("mm_first_got_range", a_fgr, 16'h8000);
    chk("mm_first_exp_range", a_fer, 16'h7F00);
    chk("mm_first_valid", a_fev, 1);
    chk("mm_pass", a_pass, 0);

    // Overflow on the ninth push, then drain eight.
    do_flush();
    for (int i = 0; i < 9; i++) begin
      w[i].r = 16'(16'h2000 + i * 3);
      w[i].l = 24'(24'h300000 + i * 5);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, w[i].r, w[i].l, 16'h0, 24'h0, 1'b0);
    step(1'b0, 1'b1, w[8].r, w[8].l, 16'h0, 24'h0, 1'b0);
    chk("ovf_before", a_ovf, 0);
    idle(1);
    chk("ovf_after9", a_ovf, 1);
    chk("ovf_model", m_ovf, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 24'h0, w[i].r, w[i].l, 1'b0);
    idle(5);
    chk("ovf_checked", a_checked, 8);
    chk("ovf_rerr", a_rerr, 0);
    chk("ovf_lerr", a_lerr, 0);
    chk("ovf_pass", a_pass, 0);

    // Underflow timing.
    do_flush();
    step(1'b1, 1'b0, 16'h0, 24'h0, 16'h1234, 24'h567890, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      chk($sformatf("unf_cycle%0d", k), a_unf, (k == 4) ? 1 : 0);
    end
    chk("unf_checked", a_checked, 0);
    chk("unf_model", m_unf, 1);

    // Reset with two results in flight.
    step(1'b1, 1'b1, 16'h4444, 24'h555555, 16'h4444, 24'h555555, 1'b0);
    step(1'b1, 1'b1, 16'h6666, 24'h777777, 16'h6666, 24'h777777, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_checked", a_checked, 0);
    chk("rst_mid_underflow", a_unf, 0);
    chk("rst_mid_pass", a_pass, 0);
    idle(2);
    reset = 1'b1;
    idle(6);
    chk("rst_after_checked", a_checked, 0);
    chk("rst_after_underflow", a_unf, 0);

    // Flush coinciding with due and push, then rerun on both latencies.
    step(1'b1, 1'b1, 16'hAAAA, 24'hBBBBBB, 16'hAAAA, 24'hBBBBBB, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 16'hCCCC, 24'hDDDDDD, 16'hCCCC, 24'hDDDDDD, 1'b1);
    idle(1);
    chk("fl_checked", a_checked, 0);
    chk("fl_underflow", a_unf, 0);
    chk("fl_overflow", a_ovf, 0);
    run_matched10();
    idle(7);
    chk("fl3_checked", a_checked, 10);
    chk("fl3_pass", a_pass, 1);
    chk("fl5_checked", b_checked, 10);
    chk("fl5_rerr", b_rerr, 0);
    chk("fl5_lerr", b_lerr, 0);
    chk("fl5_underflow", b_unf, 0);
    chk("fl5_overflow", b_ovf, 0);
    chk("fl5_pass", b_pass, 1);

    // Randomized traffic against the model.
    do_flush();
    push_hist.delete();
    for (int n = 0; n < 600; n++) begin
      iss = ($urandom % 100) < 45;
      psh = ($urandom % 100) < 45;
      fl = (n % 97) == 96;
      v.r = 16'($urandom);
      v.l = 24'($urandom);
      if (psh && !fl) push_hist.push_back(v);
      g = '0;
      if (iss) begin
        if (push_hist.size() > 0) g = push_hist.pop_front();
        else g = {16'($urandom), 24'($urandom)};
        if (($urandom % 8) == 0) g.r = g.r ^ (16'h1 << ($urandom % 16));
        if (($urandom % 8) == 1) g.l = g.l ^ (24'h1 << ($urandom % 24));
      end
      if (fl) push_hist.delete();
      step(iss, psh, v.r, v.l, g.r, g.l, fl);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/encoder_result_checker.md
ENCODER_RESULT_CHECKER -- requirements
Module: encoder_result_checker

Interface
REQ-001 SHALL have parameter RANGE_WIDTH, default 16, width of range values.
REQ-002 SHALL have parameter LOW_WIDTH, default 24, width of low values.
REQ-003 SHALL have parameter PIPE_LATENCY, default 3, cycles from symbol issue to encoder output (legal 1..15).
REQ-004 SHALL have parameter EXP_DEPTH, default 8, expected-value queue depth (power of 2, at least 2).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of all counters.
REQ-006 SHALL have ports: general_clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have ports: flush  in  1  synchronous clear of queue, tracker and counters; issue_valid  in  1  symbol entered encoder this cycle.
REQ-008 SHALL have ports: exp_valid  in  1  push expected pair; exp_range  in  RANGE_WIDTH; exp_low  in  LOW_WIDTH.
REQ-009 SHALL have ports: dut_range  in  RANGE_WIDTH  encoder RANGE_OUTPUT; dut_low  in  LOW_WIDTH  encoder LOW_OUTPUT.
REQ-010 SHALL have ports: checked_cnt, range_err_cnt, low_err_cnt  out  CNT_WIDTH each.
REQ-011 SHALL have ports: first_err_valid  out  1; first_err_idx  out  CNT_WIDTH; first_err_got_range / first_err_exp_range  out  RANGE_WIDTH; first_err_got_low / first_err_exp_low  out  LOW_WIDTH.
REQ-012 SHALL have ports: overflow  out  1  sticky; underflow  out  1  sticky; pass  out  1.

Function
REQ-013 SHALL delay issue_valid through a PIPE_LATENCY-stage shift register; its last stage (due) marks the cycle dut_range/dut_low hold the result of that issue.
REQ-014 SHALL store exp_range/exp_low in a FIFO on exp_valid; push and pop in the same cycle SHALL both occur, occupancy unchanged.
REQ-015 SHALL, on due with queue non-empty, pop the head and compare: range mismatch increments range_err_cnt, low mismatch increments low_err_cnt, checked_cnt always increments; all updates visible the following cycle.
REQ-016 SHALL, on due with queue empty (including a same-cycle push), perform no compare and set underflow.
REQ-017 SHALL, on exp_valid with queue full and no same-cycle pop, drop the push and set overflow.
REQ-018 SHALL, on the first compare with any mismatch, capture index (value of checked_cnt before increment), got and expected values, and set first_err_valid; later mismatches SHALL not overwrite the capture.
REQ-019 SHALL saturate every counter at all-ones.
REQ-020 SHALL drive pass = 1 only when checked_cnt > 0, both error counters are 0, overflow and underflow are 0.
REQ-021 SHALL give flush priority over all same-cycle events: queue emptied, tracker zeroed, counters, captures and stickies cleared; inputs during the flush cycle are ignored.

Reset
REQ-022 SHALL, while reset is low, asynchronously force all counters to 0, first_err_* to 0, overflow/underflow/pass to 0, queue empty, tracker zeroed.
REQ-023 SHALL resume normal operation on the first rising edge after reset deasserts; results in flight at reset assertion are discarded.

Structure
REQ-024 SHALL place PIPE_LATENCY default, EXP_DEPTH default and a compare-result typedef (range_ok, low_ok) in shared package encoder_verif_pkg.
REQ-025 SHALL implement the expected queue as sub-module expected_fifo (parametrised data width and depth, full/empty outputs, registered read head).
REQ-026 SHALL contain no latches, no combinational paths from inputs to outputs.

Verification
REQ-027 Directed: 10 issues with matching expected values, PIPE_LATENCY=3 -> checked_cnt=10, error counts 0, pass=1 three cycles after last issue.
REQ-028 Directed: 5 issues, 3rd result dut_range=0x8000 vs expected 0x7F00 -> range_err_cnt=1, low_err_cnt=0, first_err_idx=2, first_err_got_range=0x8000, pass=0.
REQ-029 Directed: 9 pushes, no issue, EXP_DEPTH=8 -> overflow=1 after 9th push, subsequent 8 issues -> checked_cnt=8.
REQ-030 Directed: issue with no expected push -> underflow=1 exactly PIPE_LATENCY cycles later, checked_cnt stays 0.
REQ-031 Directed: reset low mid-run with 2 results in flight -> all outputs 0 immediately, no compare of discarded results after release.
REQ-032 Directed: flush coincident with due and exp_valid -> all counters 0, queue empty next cycle; then rerun REQ-027 with PIPE_LATENCY=5 -> identical counts.
